// File: rtl/fifo_wr_arbiter_if.sv
`timescale 1ns/1ps
// fifo_wr_arbiter_if
// Bundle of producer handshakes and the shared FIFO write-port pins.
// slave  : arbiter side (consumes producer requests, drives FIFO writes)
// master : producer/FIFO side (drives requests and FIFO status)
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          fifo_wr_req;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_full;
  logic [ADDR_WIDTH:0]           fifo_num;

  modport slave (
    input  req_valid, req_last, req_data, fifo_wr_full, fifo_num,
    output req_ready, grant, busy, fifo_wr_req, fifo_wr_data
  );

  modport master (
    output req_valid, req_last, req_data, fifo_wr_full, fifo_num,
    input  req_ready, grant, busy, fifo_wr_req, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// fifo_wr_arbiter
// Round-robin write-port arbiter sharing one synchronous FIFO among
// NUM_REQ producers. A grant is held for a burst that ends on the owner's
// last flag or after MAX_BURST beats, followed by one idle bubble.
// Optional build macro FIFO_WR_ARB_SPACE_CHECK_EN: when defined, a grant is
// only issued if the FIFO has room for a full MAX_BURST burst, so a granted
// burst never stalls on full (wr_full still gates writes as a safety net).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; round-robin search for the next valid requester
// S_GRANT | owner holds the FIFO write port until its burst ends
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rstn,
  fifo_wr_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic                 pick_found;
  logic [PTR_W-1:0]     pick_idx;
  logic                 space_ok;
  logic                 beat;
  logic                 burst_end;

  logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign req_slice[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef FIFO_WR_ARB_SPACE_CHECK_EN
  localparam int NUM_W = ADDR_WIDTH + 1;
  // Largest fill level that still leaves room for a whole burst.
  localparam logic [ADDR_WIDTH:0] NUM_LIMIT = NUM_W'(DEPTH - MAX_BURST);
  assign space_ok = (bus.fifo_num <= NUM_LIMIT);
`else
  logic unused_fifo_num;
  assign space_ok        = 1'b1;
  assign unused_fifo_num = ^bus.fifo_num;
`endif

  // Round-robin search starting just after the previous owner
  always_comb begin
    logic [PTR_W-1:0] idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Steer the owner's handshake and data onto the FIFO write port
  always_comb begin
    bus.req_ready    = '0;
    bus.fifo_wr_req  = 1'b0;
    bus.fifo_wr_data = '0;
    if (state_q == S_GRANT) begin
      bus.req_ready[owner_q] = !bus.fifo_wr_full;
      bus.fifo_wr_req        = bus.req_valid[owner_q] & !bus.fifo_wr_full;
      bus.fifo_wr_data       = req_slice[owner_q];
    end
  end

  assign beat      = bus.fifo_wr_req;
  assign burst_end = beat & (bus.req_last[owner_q] | (beat_cnt_q == LAST_BEAT));

  // Next-state: grant on a found requester, release on burst end
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found && space_ok) begin
          state_d    = S_GRANT;
          owner_d    = pick_idx;
          grant_d    = ONE_HOT0 << pick_idx;
          beat_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (burst_end) begin
          state_d    = S_IDLE;
          grant_d    = '0;
          rr_ptr_d   = owner_q;
          beat_cnt_d = '0;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= PTR_RESET;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q == S_GRANT);

  // Structural invariants of the grant and burst counter
  a_grant_onehot : assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(bus.grant));
  a_busy_grant   : assert property (@(posedge clk) disable iff (!rstn)
    bus.busy == (bus.grant != '0));
  a_beat_range   : assert property (@(posedge clk) disable iff (!rstn)
    beat_cnt_q < CNT_W'(MAX_BURST));
  a_wr_owner     : assert property (@(posedge clk) disable iff (!rstn)
    bus.fifo_wr_req |-> ((bus.req_ready & bus.req_valid & bus.grant) != '0));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// tb_fifo_wr_arbiter
// Directed scenarios plus a randomized run, each compared cycle by cycle
// against a burst-level reference model of the arbiter.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int MB = 4;
  localparam int OW = 2*N + 2 + DW;

  logic clk;
  logic rstn;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: current owner (-1 when none), last owner, beats so far.
  int m_owner;
  int m_rr;
  int m_beats;
  int sent [N];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];

  always @(negedge clk) begin
    if (rstn && bus.fifo_wr_req) got_q.push_back(bus.fifo_wr_data);
  end

  task automatic model_reset();
    m_owner = -1;
    m_rr    = N - 1;
    m_beats = 0;
  endtask

  function automatic bit model_space_ok();
`ifdef FIFO_WR_ARB_SPACE_CHECK_EN
    return ((2 ** AW) - int'(bus.fifo_num)) >= MB;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge();
    if (!rstn) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      if (model_space_ok()) begin
        int found;
        found = -1;
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_rr + k) % N;
          if (found < 0 && bus.req_valid[idx]) found = idx;
        end
        m_owner = found;
      end
    end else if (bus.req_valid[m_owner] && !bus.fifo_wr_full) begin
      exp_q.push_back(bus.req_data[m_owner*DW +: DW]);
      sent[m_owner]++;
      m_beats++;
      if (bus.req_last[m_owner] || m_beats == MB) begin
        m_rr    = m_owner;
        m_owner = -1;
        m_beats = 0;
      end
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [N-1:0]  g, r;
    logic          b, w;
    logic [DW-1:0] dd;
    g = '0; r = '0; b = 1'b0; w = 1'b0; dd = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      b          = 1'b1;
      r[m_owner] = !bus.fifo_wr_full;
      w          = bus.req_valid[m_owner] & !bus.fifo_wr_full;
      dd         = bus.req_data[m_owner*DW +: DW];
    end
    return {g, b, w, r, dd};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    bus.req_data[i*DW +: DW] = v;
  endtask

  task automatic clear_inputs();
    bus.req_valid    = '0;
    bus.req_last     = '0;
    bus.req_data     = '0;
    bus.fifo_wr_full = 1'b0;
    bus.fifo_num     = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    model_reset();
    tick();
    tick();
    rstn = 1'b1;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    logic [OW-1:0] act;
    rstn = 1'b0;
    clear_inputs();
    bus.req_valid = '1;
    bus.req_last  = '1;
    bus.req_data  = 32'hDEADBEEF;
    model_reset();
    tick();
    tick();
    act = {bus.grant, bus.busy, bus.fifo_wr_req, bus.req_ready, bus.fifo_wr_data};
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", act);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.grant !== '0) begin
      errors++;
      $display("FAIL reset_no_early_grant: got %b, expected 0000", bus.grant);
    end
    tick();
    checks++;
    if (bus.grant !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b, expected 0001", bus.grant);
    end
  endtask

  task automatic test_single_burst();
    logic [OW-1:0] act, exp;
    int b0;
    do_reset();
    b0 = sent[0];
    for (int c = 0; c < 10; c++) begin
      int n;
      n = sent[0] - b0;
      bus.req_valid = (n < 3) ? 4'b0001 : 4'b0000;
      bus.req_last  = (n == 2) ? 4'b0001 : 4'b0000;
      set_data(0, 8'hA0 + 8'(n));
      #1;
      act = {bus.grant, bus.busy, bus.fifo_wr_req, bus.req_ready, bus.fifo_wr_data};
      exp = model_out();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL single_burst cyc %0d: got %h, expected %h", c, act, exp);
      end
      if (c == 1) begin
        checks++;
        if (bus.grant !== 4'b0001) begin
          errors++;
          $display("FAIL single_grant_latency: got %b, expected 0001", bus.grant);
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.grant !== 4'b0000) begin
          errors++;
          $display("FAIL single_idle_after_last: got %b, expected 0000", bus.grant);
        end
      end
      tick();
    end
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL single_write_count: got %0d, expected 3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_q[k] !== 8'hA0 + 8'(k)) begin
          errors++;
          $display("FAIL single_write_data[%0d]: got %h, expected %h", k, got_q[k], 8'hA0 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_rotation();
    logic [OW-1:0] act, exp;
    logic [N-1:0] prev;
    logic [N-1:0] gseq [$];
    int bcnt [$];
    int beats;
    do_reset();
    prev = '0;
    beats = 0;
    bus.req_valid = '1;
    bus.req_last  = '0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < N; i++) set_data(i, 8'(i*16 + (sent[i] & 15)));
      #1;
      act = {bus.grant, bus.busy, bus.fifo_wr_req, bus.req_ready, bus.fifo_wr_data};
      exp = model_out();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL rotation cyc %0d: got %h, expected %h", c, act, exp);
      end
      if (bus.grant !== prev) begin
        if (prev != '0) bcnt.push_back(beats);
        if (bus.grant != '0) begin
          gseq.push_back(bus.grant);
          beats = 0;
        end
        prev = bus.grant;
      end
      if (bus.fifo_wr_req) beats++;
      tick();
    end
    checks++;
    if (gseq.size() < 5 || bcnt.size() < 5) begin
      errors++;
      $display("FAIL rotation_burst_count: got %0d grants/%0d bursts, expected at least 5", gseq.size(), bcnt.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        logic [N-1:0] eg;
        eg = 4'(1 << (k % N));
        checks++;
        if (gseq[k] !== eg) begin
          errors++;
          $display("FAIL rotation_order[%0d]: got %b, expected %b", k, gseq[k], eg);
        end
        checks++;
        if (bcnt[k] != MB) begin
          errors++;
          $display("FAIL rotation_beats[%0d]: got %0d, expected %0d", k, bcnt[k], MB);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    logic [OW-1:0] act, exp;
    int b1;
    do_reset();
    b1 = sent[1];
    for (int c = 0; c < 16; c++) begin
      int n;
      n = sent[1] - b1;
      bus.req_valid    = (n < 4) ? 4'b0010 : 4'b0000;
      bus.req_last     = '0;
      bus.fifo_wr_full = (c >= 3 && c < 8);
      set_data(1, 8'h10 + 8'(n));
      #1;
      act = {bus.grant, bus.busy, bus.fifo_wr_req, bus.req_ready, bus.fifo_wr_data};
      exp = model_out();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL full_stall cyc %0d: got %h, expected %h", c, act, exp);
      end
      if (bus.fifo_wr_full) begin
        checks++;
        if (bus.req_ready !== '0 || bus.fifo_wr_req !== 1'b0 || bus.grant !== 4'b0010) begin
          errors++;
          $display("FAIL full_stall_hold cyc %0d: got ready=%b wr=%b grant=%b, expected 0000/0/0010",
                   c, bus.req_ready, bus.fifo_wr_req, bus.grant);
        end
      end
      tick();
    end
    checks++;
    if (got_q.size() != MB) begin
      errors++;
      $display("FAIL full_stall_beats: got %0d, expected %0d", got_q.size(), MB);
    end else begin
      for (int k = 0; k < MB; k++) begin
        checks++;
        if (got_q[k] !== 8'h10 + 8'(k)) begin
          errors++;
          $display("FAIL full_stall_data[%0d]: got %h, expected %h", k, got_q[k], 8'h10 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_valid_drop();
    logic [OW-1:0] act, exp;
    int b0, b2, first2;
    do_reset();
    b0 = sent[0];
    b2 = sent[2];
    first2 = -1;
    for (int c = 0; c < 14; c++) begin
      int n;
      logic v0;
      n  = sent[0] - b0;
      v0 = (n < MB) && !(c >= 2 && c < 5);
      bus.req_valid = {1'b0, 1'b1, 1'b0, v0};
      bus.req_last  = '0;
      set_data(0, 8'(n));
      set_data(2, 8'h20 + 8'(sent[2] - b2));
      #1;
      act = {bus.grant, bus.busy, bus.fifo_wr_req, bus.req_ready, bus.fifo_wr_data};
      exp = model_out();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL valid_drop cyc %0d: got %h, expected %h", c, act, exp);
      end
      if (c >= 2 && c < 5) begin
        checks++;
        if (bus.grant !== 4'b0001 || bus.fifo_wr_req !== 1'b0) begin
          errors++;
          $display("FAIL valid_drop_hold cyc %0d: got grant=%b wr=%b, expected 0001/0", c, bus.grant, bus.fifo_wr_req);
        end
      end
      if (bus.grant === 4'b0100 && first2 < 0) begin
        first2 = c;
        checks++;
        if (got_q.size() != MB) begin
          errors++;
          $display("FAIL valid_drop_order: got %0d writes before req2 grant, expected %0d", got_q.size(), MB);
        end
      end
      tick();
    end
    checks++;
    if (first2 < 0) begin
      errors++;
      $display("FAIL valid_drop_req2_grant: got no grant within 14 cycles, expected 0100");
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [OW-1:0] act, exp;
    int b0;
    do_reset();
    b0 = sent[0];
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = 4'b0001;
      bus.req_last  = '0;
      set_data(0, 8'h50 + 8'(sent[0] - b0));
      #1;
      act = {bus.grant, bus.busy, bus.fifo_wr_req, bus.req_ready, bus.fifo_wr_data};
      exp = model_out();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got %h, expected %h", c, act, exp);
      end
      if (c < 2) tick();
    end
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    act = {bus.grant, bus.busy, bus.fifo_wr_req, bus.req_ready, bus.fifo_wr_data};
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h, expected 0", act);
    end
    bus.req_valid = 4'b1000;
    #2;
    rstn = 1'b1;
    tick();
    checks++;
    if (bus.grant !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_rr_ptr: got %b, expected 1000", bus.grant);
    end
  endtask

  task automatic test_space_check();
    logic [OW-1:0] act, exp;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = 4'b0001;
      bus.req_last  = '0;
      bus.fifo_num  = (c < 5) ? 5'd13 : 5'd12;
      set_data(0, 8'h70 + 8'(c));
      #1;
      act = {bus.grant, bus.busy, bus.fifo_wr_req, bus.req_ready, bus.fifo_wr_data};
      exp = model_out();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL space_check cyc %0d: got %h, expected %h", c, act, exp);
      end
`ifdef FIFO_WR_ARB_SPACE_CHECK_EN
      if (c >= 1 && c <= 5) begin
        checks++;
        if (bus.grant !== 4'b0000) begin
          errors++;
          $display("FAIL space_block cyc %0d: got %b, expected 0000", c, bus.grant);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.grant !== 4'b0001) begin
          errors++;
          $display("FAIL space_grant: got %b, expected 0001", bus.grant);
        end
      end
`else
      if (c == 1) begin
        checks++;
        if (bus.grant !== 4'b0001) begin
          errors++;
          $display("FAIL space_ignored: got %b, expected 0001", bus.grant);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] act, exp;
    int mism;
    do_reset();
    mism = 0;
    for (int c = 0; c < 400; c++) begin
      bus.req_valid    = 4'($urandom_range(0, 15));
      bus.req_last     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      bus.req_data     = 32'($urandom);
      bus.fifo_wr_full = ($urandom_range(0, 4) == 0);
      bus.fifo_num     = 5'($urandom_range(0, 16));
      #1;
      act = {bus.grant, bus.busy, bus.fifo_wr_req, bus.req_ready, bus.fifo_wr_data};
      exp = model_out();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL random cyc %0d: got %h, expected %h", c, act, exp);
      end
      tick();
    end
    clear_inputs();
    tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_write_count: got %0d, expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        if (got_q[k] !== exp_q[k]) mism++;
      end
      checks++;
      if (mism != 0) begin
        errors++;
        $display("FAIL random_write_data: got %0d differing writes, expected 0", mism);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) sent[i] = 0;
    model_reset();
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_rotation();
    test_full_stall();
    test_valid_drop();
    test_reset_mid_burst();
    test_space_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
